t05_bit_packer: RTL and testbench

- Downstream stage of header synthesis. Consumes the serial bit stream (`bit_in` qualified by `bit_valid`) from the header/path bit emitters.
- Assembles bits MSB-first into WORD_W-bit words and hands them to the SRAM/SPI write controller over a valid/ready handshake.
- Supports an end-of-stream flush that zero-pads and emits the final partial word, reporting how many of its bits are meaningful.

---
 rtl/t05_pkg.sv | 15 +
 rtl/t05_bit_packer.sv | 172 +++++++++++++++++
 tb/tb_t05_bit_packer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t05_pkg.sv
// Shared definitions for the header-synthesis back end: packer FSM states and
// the default word width that the SRAM/SPI write controller also uses.
package t05_pkg;

    // Default packed word width shared with the write controller
    localparam int unsigned T05_WORD_W = 32;

    // Bit packer control states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } packer_state_e;

endpackage : t05_pkg

// File: rtl/t05_bit_packer.sv
// t05_bit_packer: packs a serial bit stream MSB-first into WORD_W-bit words and
// hands them downstream over valid/ready, with a zero-padding end-of-stream
// flush that reports how many bits of the final word are meaningful.
//
// Build option: define T05_BIT_PACKER_COUNT_EN to add the total_bits output,
// a wrapping count of accepted bits since reset.
//
// Storage is an accumulator (acc/cnt) feeding a one-entry holding register
// (hold/hold_bits/hold_valid) that drives the write port directly, so wr_data
// stays stable while the downstream stalls.
module t05_bit_packer
    import t05_pkg::*;
#(
    parameter int unsigned WORD_W = T05_WORD_W,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              flush,
    input  logic              wr_ready,
    output logic [WORD_W-1:0] wr_data,
    output logic [CNT_W-1:0]  wr_bits,
    output logic              wr_valid,
    output logic              busy,
    output logic              overflow,
    output logic              flush_done
`ifdef T05_BIT_PACKER_COUNT_EN
    ,
    output logic [31:0]       total_bits
`endif
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);

    packer_state_e     state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  hold_bits_q, hold_bits_d;
    logic              hold_valid_q, hold_valid_d;
    logic              overflow_q, overflow_d;
    logic              flush_done_q, flush_done_d;
    logic              bit_accept;

    logic              cnt_full;
    logic              hold_free;
    logic              take;

    // Hold can be (re)loaded when empty or being consumed this cycle
    assign cnt_full  = (cnt_q == FULL);
    assign hold_free = !hold_valid_q || wr_ready;
    assign take      = cnt_full && hold_free;

    // Write port and status are driven straight from registers, except busy,
    // which must react to wr_ready in the same cycle so upstream pauses only
    // when a bit would really be lost.
    assign wr_data    = hold_q;
    assign wr_bits    = hold_bits_q;
    assign wr_valid   = hold_valid_q;
    assign overflow   = overflow_q;
    assign flush_done = flush_done_q;
    assign busy       = cnt_full && hold_valid_q && !wr_ready;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_bits_q  <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_bits_q  <= hold_bits_d;
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Next-state, accumulate, transfer and flush control
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_bits_d  = hold_bits_q;
        hold_valid_d = hold_valid_q && !wr_ready;
        overflow_d   = overflow_q;
        flush_done_d = 1'b0;
        bit_accept   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                // Full accumulator moves into hold as soon as hold frees up
                if (take) begin
                    hold_d       = acc_q;
                    hold_bits_d  = FULL;
                    hold_valid_d = 1'b1;
                    cnt_d        = '0;
                end
                // A bit arriving with the transfer starts the next word
                if (bit_valid) begin
                    if (!cnt_full || take) begin
                        bit_accept = 1'b1;
                        acc_d      = {acc_q[WORD_W-2:0], bit_in};
                        cnt_d      = (take ? CNT_W'(0) : cnt_q) + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (bit_valid) begin
                    overflow_d = 1'b1;
                end
                // Left-justify the residue; a full word goes out unpadded
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (hold_free) begin
                    hold_d       = acc_q << (FULL - cnt_q);
                    hold_bits_d  = cnt_q;
                    hold_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (bit_valid) begin
                    overflow_d = 1'b1;
                end
                if (hold_free) begin
                    flush_done_d = 1'b1;
                    state_d      = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

`ifdef T05_BIT_PACKER_COUNT_EN
    logic [31:0] total_q;

    // Accepted-bit counter for compression-ratio reporting
    always_ff @(posedge clk) begin
        if (!rst) begin
            total_q <= '0;
        end else if (bit_accept) begin
            total_q <= total_q + 32'd1;
        end
    end

    assign total_bits = total_q;
`endif

endmodule : t05_bit_packer

// File: tb/tb_t05_bit_packer.sv
// Self-checking bench for t05_bit_packer (WORD_W = 32).
module tb_t05_bit_packer;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    logic          clk;
    logic          rst;
    logic          bit_in;
    logic          bit_valid;
    logic          flush;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic [CW-1:0] wr_bits;
    logic          wr_valid;
    logic          busy;
    logic          overflow;
    logic          flush_done;
`ifdef T05_BIT_PACKER_COUNT_EN
    logic [31:0]   total_bits;
`endif

    t05_bit_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_bits    (wr_bits),
        .wr_valid   (wr_valid),
        .busy       (busy),
        .overflow   (overflow),
        .flush_done (flush_done)
`ifdef T05_BIT_PACKER_COUNT_EN
        ,
        .total_bits (total_bits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stream model: accepted bits in arrival order, cut into words
    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] bits;
    } word_t;

    logic  mbits[$];
    word_t exp_q[$];
    int    model_accepted = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_bit(input logic b);
        word_t w;
        mbits.push_back(b);
        model_accepted++;
        if (mbits.size() == W) begin
            w = '0;
            for (int i = 0; i < int'(W); i++) w.data[W-1-i] = mbits[i];
            w.bits = CW'(W);
            exp_q.push_back(w);
            mbits.delete();
        end
    endtask

    task automatic model_flush();
        word_t w;
        if (mbits.size() > 0) begin
            w = '0;
            for (int i = 0; i < mbits.size(); i++) w.data[W-1-i] = mbits[i];
            w.bits = CW'(mbits.size());
            exp_q.push_back(w);
            mbits.delete();
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        exp_q.delete();
        model_accepted = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input bit keep);
        bit_in    = b;
        bit_valid = 1'b1;
        if (keep) model_bit(b);
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i], 1'b1);
    endtask

    task automatic wait_flush_done(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!flush_done && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 64'(flush_done), 64'd1);
    endtask

    // Compare process: every handshake against the model, and stall stability
    logic          stall_prev = 1'b0;
    logic [W-1:0]  stall_data;
    logic [CW-1:0] stall_bits;

    always @(negedge clk) begin
        word_t e;
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(wr_valid), 64'd1);
                check("stall_data", 64'(wr_data), 64'(stall_data));
                check("stall_bits", 64'(wr_bits), 64'(stall_bits));
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(wr_data), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(wr_data), 64'(e.data));
                    check("word_bits", 64'(wr_bits), 64'(e.bits));
                end
            end
            stall_prev = wr_valid && !wr_ready;
            stall_data = wr_data;
            stall_bits = wr_bits;
        end
    end

    initial begin
        rst       = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        flush     = 1'b0;
        wr_ready  = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_wr_bits", 64'(wr_bits), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        rst = 1'b1;
        tick();

        // Full word, one cycle from last bit to wr_valid
        send_word(32'hA5A5_F00F, 32);
        check("t1_not_yet", 64'(wr_valid), 64'd0);
        tick();
        check("t1_valid", 64'(wr_valid), 64'd1);
        check("t1_data", 64'(wr_data), 64'hA5A5_F00F);
        check("t1_bits", 64'(wr_bits), 64'd32);
        tick();
        check("t1_drained", 64'(wr_valid), 64'd0);

        // 9-bit header then flush
        send_word(32'h0000_0141, 9);
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
        check("t2_fd_early", 64'(flush_done), 64'd0);
        tick();
        check("t2_valid", 64'(wr_valid), 64'd1);
        check("t2_data", 64'(wr_data), 64'hA080_0000);
        check("t2_bits", 64'(wr_bits), 64'd9);
        tick();
        check("t2_flush_done", 64'(flush_done), 64'd1);
        check("t2_no_word", 64'(wr_valid), 64'd0);
        tick();
        check("t2_fd_pulse", 64'(flush_done), 64'd0);

        // Backpressure: 64 bits stalled, 65th dropped, then drain in order
        wr_ready = 1'b0;
        send_word(32'h1234_5678, 32);
        send_word(32'hDEAD_BEEF, 32);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_hold_w1", 64'(wr_data), 64'h1234_5678);
        check("t3_no_ovf", 64'(overflow), 64'd0);
        drive_bit(1'b1, 1'b0);
        check("t3_overflow", 64'(overflow), 64'd1);
        wr_ready = 1'b1;
        #1;
        check("t3_busy_falls", 64'(busy), 64'd0);
        tick();
        check("t3_w2_data", 64'(wr_data), 64'hDEAD_BEEF);
        check("t3_w2_valid", 64'(wr_valid), 64'd1);
        tick();
        check("t3_drained", 64'(wr_valid), 64'd0);
        check("t3_ovf_sticky", 64'(overflow), 64'd1);

        // Flush with nothing buffered
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
        check("t4_fd_c1", 64'(flush_done), 64'd0);
        tick();
        check("t4_fd_c2", 64'(flush_done), 64'd0);
        check("t4_no_word", 64'(wr_valid), 64'd0);
        tick();
        check("t4_flush_done", 64'(flush_done), 64'd1);
        tick();
        check("t4_fd_pulse", 64'(flush_done), 64'd0);

        // Reset mid-word drops pending word and residue
        wr_ready = 1'b0;
        send_word(32'h5A5A_0FF0, 32);
        send_word(32'h0001_5555, 17);
        check("t5_pending", 64'(wr_valid), 64'd1);
        rst = 1'b0;
        model_reset();
        tick();
        check("t5_rst_valid", 64'(wr_valid), 64'd0);
        check("t5_rst_data", 64'(wr_data), 64'd0);
        check("t5_rst_bits", 64'(wr_bits), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_ovf", 64'(overflow), 64'd0);
        check("t5_rst_fd", 64'(flush_done), 64'd0);
        rst      = 1'b1;
        wr_ready = 1'b1;
        send_word(32'h0F0F_1234, 32);
        tick();
        check("t5_fresh", 64'(wr_data), 64'h0F0F_1234);
        tick();

        // Bit in the same cycle as flush is included
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b1);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        flush     = 1'b1;
        model_bit(1'b0);
        model_flush();
        tick();
        bit_valid = 1'b0;
        flush     = 1'b0;
        tick();
        check("t6_data", 64'(wr_data), 64'hB000_0000);
        check("t6_bits", 64'(wr_bits), 64'd5);
        tick();
        check("t6_flush_done", 64'(flush_done), 64'd1);
        tick();

        // Flush with a full accumulator behind a stalled hold: no padded word,
        // repeated flush ignored, bits during flush dropped
        wr_ready = 1'b0;
        send_word(32'hCAFE_F00D, 32);
        send_word(32'h8000_0001, 32);
        check("t7_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        model_flush();
        tick();
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        tick();
        flush     = 1'b0;
        bit_valid = 1'b0;
        check("t7_overflow", 64'(overflow), 64'd1);
        check("t7_hold", 64'(wr_data), 64'hCAFE_F00D);
        check("t7_fd_wait", 64'(flush_done), 64'd0);
        wr_ready = 1'b1;
        wait_flush_done("t7_flush_done", 8);
        tick();
        check("t7_fd_pulse", 64'(flush_done), 64'd0);
        check("t7_no_pad", 64'(wr_valid), 64'd0);

`ifdef T05_BIT_PACKER_COUNT_EN
        check("total_bits", 64'(total_bits), 64'(model_accepted));
`endif

        repeat (3) tick();
        check("all_words_out", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_t05_bit_packer
